// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit owning HI/LO; results land after a fixed busy window.
module ex_mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        start,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    logic [CW-1:0] count, load;
    logic [63:0]   pending, prod_s, prod_u, result;
    logic [31:0]   dvs, q_s, r_s, q_u, r_u;
    logic          pend_wr, long_op, ovf;
    assign start = op_valid && !busy && !cancel && op != 3'd0 && op != 3'd7;
    // Divisor forced to 1 on divide-by-zero so the arithmetic stays defined; the write is suppressed instead.
    always_comb begin
        prod_s  = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u  = {32'd0, src_a} * {32'd0, src_b};
        dvs     = src_b == '0 ? 32'd1 : src_b;
        ovf     = src_a == 32'h8000_0000 && src_b == 32'hffff_ffff;
        q_s     = ovf ? src_a : 32'($signed(src_a) / $signed(dvs));
        r_s     = ovf ? '0 : 32'($signed(src_a) % $signed(dvs));
        q_u     = src_a / dvs;
        r_u     = src_a % dvs;
        result  = op == 3'd1 ? prod_s : op == 3'd2 ? prod_u : op == 3'd3 ? {r_s, q_s} : {r_u, q_u};
        long_op = op >= 3'd1 && op <= 3'd4;
        load    = op <= 3'd2 ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            count   <= '0;
            pending <= '0;
            pend_wr <= 1'b0;
        end else if (start) begin
            if (op == 3'd5) hi <= src_a;
            if (op == 3'd6) lo <= src_a;
            if (long_op) begin
                pending <= result;
                pend_wr <= op <= 3'd2 || src_b != '0;
                count   <= load;
                busy    <= 1'b1;
            end
        end else if (busy) begin
            if (count == CW'(1)) begin
                if (pend_wr) {hi, lo} <= pending;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: vector table, hand-written corner sequences and random ops against an arithmetic model of HI/LO.
module tb_ex_mdu;
    localparam int MUL = 5;
    localparam int DIV = 10;
    logic        clk = 0, reset = 1, op_valid = 0, cancel = 0;
    logic [2:0]  op = 0;
    logic [31:0] src_a = 0, src_b = 0;
    logic        busy, start;
    logic [31:0] hi, lo;
    logic [31:0] mhi, mlo;
    int          n_cmp = 0, n_bad = 0;

    ex_mdu #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .busy(busy), .start(start), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: 64-bit arithmetic straight from the ISA rules.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (o)
            3'd1: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
            3'd2: begin p = ua * ub; mhi = p[63:32]; mlo = p[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; mlo = q[31:0]; mhi = r[31:0]; end
            3'd4: if (b != 0) begin q = ua / ub; r = ua % ub; mlo = q[31:0]; mhi = r[31:0]; end
            3'd5: mhi = a;
            3'd6: mlo = a;
            default: ;
        endcase
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic c);
        logic es;
        int   n, eb;
        es = o != 0 && o != 7 && !c;
        eb = !es ? 0 : (o == 1 || o == 2) ? MUL : (o == 3 || o == 4) ? DIV : 0;
        @(negedge clk);
        op_valid = 1; op = o; src_a = a; src_b = b; cancel = c;
        #1 chk({tag, " start"}, 64'(start), 64'(es));
        @(negedge clk);
        op_valid = 0; cancel = 0;
        count_busy(n);
        if (es) model_apply(o, a, b);
        chk({tag, " busy_cycles"}, 64'(n), 64'(eb));
        chk({tag, " hi"}, 64'(hi), 64'(mhi));
        chk({tag, " lo"}, 64'(lo), 64'(mlo));
    endtask

    initial begin
        int n;
        tbl[0]  = '{3'd5, 32'h12345678, 32'h0, 32'h12345678, 32'h0};
        tbl[1]  = '{3'd6, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0};
        tbl[2]  = '{3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[3]  = '{3'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA};
        tbl[4]  = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        tbl[6]  = '{3'd5, 32'h11, 32'h0, 32'h11, 32'h80000000};
        tbl[7]  = '{3'd6, 32'h22, 32'h0, 32'h11, 32'h22};
        tbl[8]  = '{3'd4, 32'h1234, 32'h0, 32'h11, 32'h22};
        tbl[9]  = '{3'd0, 32'hAAAA, 32'hBBBB, 32'h11, 32'h22};
        tbl[10] = '{3'd7, 32'hAAAA, 32'hBBBB, 32'h11, 32'h22};
        tbl[11] = '{3'd4, 32'd100, 32'd7, 32'd2, 32'd14};
        mhi = 0; mlo = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset lo", 64'(lo), 64'(0));
        chk("reset start", 64'(start), 64'(0));
        foreach (tbl[i]) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
            chk($sformatf("vec%0d table_hi", i), 64'(hi), 64'(tbl[i].ehi));
            chk($sformatf("vec%0d table_lo", i), 64'(lo), 64'(tbl[i].elo));
        end
        run_op("cancel_mult", 3'd1, 32'd9, 32'd9, 1'b1);
        // Cancel arriving after acceptance must not abort the running op.
        @(negedge clk);
        op_valid = 1; op = 3'd1; src_a = 32'd7; src_b = 32'hFFFFFFFD;
        @(negedge clk);
        op_valid = 0; cancel = 1;
        chk("late_cancel busy", 64'(busy), 64'(1));
        @(negedge clk);
        cancel = 0;
        count_busy(n);
        model_apply(3'd1, 32'd7, 32'hFFFFFFFD);
        chk("late_cancel busy_cycles", 64'(n + 1), 64'(MUL));
        chk("late_cancel hi", 64'(hi), 64'(32'hFFFFFFFF));
        chk("late_cancel lo", 64'(lo), 64'(32'hFFFFFFEB));
        // MTLO held while busy is ignored; lo stays old until the product lands.
        @(negedge clk);
        op_valid = 1; op = 3'd1; src_a = 32'h10000; src_b = 32'h10003;
        @(negedge clk);
        op = 3'd6; src_a = 32'hDEADBEEF;
        n = 0;
        while (busy && n < 100) begin
            n++;
            #1 chk("held_mtlo start", 64'(start), 64'(0));
            chk("held_mtlo lo_old", 64'(lo), 64'(mlo));
            @(negedge clk);
        end
        op_valid = 0;
        model_apply(3'd1, 32'h10000, 32'h10003);
        chk("held_mtlo busy_cycles", 64'(n), 64'(MUL));
        chk("held_mtlo hi", 64'(hi), 64'(32'h1));
        chk("held_mtlo lo", 64'(lo), 64'(32'h30000));
        // Reset in the third busy cycle aborts the op.
        @(negedge clk);
        op_valid = 1; op = 3'd1; src_a = 32'h55; src_b = 32'h66;
        @(negedge clk);
        op_valid = 0;
        repeat (2) @(negedge clk);
        chk("abort busy_before", 64'(busy), 64'(1));
        reset = 1;
        @(negedge clk);
        reset = 0;
        mhi = 0; mlo = 0;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort hi", 64'(hi), 64'(0));
        chk("abort lo", 64'(lo), 64'(0));
        repeat (12) @(negedge clk);
        chk("abort late_busy", 64'(busy), 64'(0));
        chk("abort late_hi", 64'(hi), 64'(0));
        chk("abort late_lo", 64'(lo), 64'(0));
        for (int k = 0; k < 80; k++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            logic        c;
            o = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 5) == 0 ? 32'h80000000 : $urandom;
            b = $urandom_range(0, 5) == 0 ? 32'h0 : $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom;
            c = $urandom_range(0, 7) == 0;
            run_op($sformatf("rnd%0d", k), o, a, b, c);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
